// File: rtl/fifo_sync_ctrl_if.sv
// rtl/fifo_sync_ctrl_if.sv - request/response bundle for the fifo_sync_ctrl FIFO
interface fifo_sync_ctrl_if #(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_DEPTH = 16
);
    localparam int SIZE_ADDR = $clog2(SIZE_DEPTH);

    logic                 i_flush;
    logic                 i_wr_en;
    logic [SIZE_DATA-1:0] i_data;
    logic                 i_rd_en;
    logic                 i_err_clr;
    logic [SIZE_DATA-1:0] o_data;
    logic                 o_valid;
    logic [SIZE_ADDR:0]   o_count;
    logic                 o_fifo_full;
    logic                 o_fifo_empty;
    logic                 o_almost_full;
    logic                 o_almost_empty;
    logic                 o_error_overrun;
    logic                 o_error_underrun;

    modport master (
        output i_flush, i_wr_en, i_data, i_rd_en, i_err_clr,
        input  o_data, o_valid, o_count, o_fifo_full, o_fifo_empty,
               o_almost_full, o_almost_empty, o_error_overrun, o_error_underrun
    );

    modport slave (
        input  i_flush, i_wr_en, i_data, i_rd_en, i_err_clr,
        output o_data, o_valid, o_count, o_fifo_full, o_fifo_empty,
               o_almost_full, o_almost_empty, o_error_overrun, o_error_underrun
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO with count, watermarks, flush, FWFT option
// Optional sticky overrun/underrun flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_ctrl #(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = SIZE_DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    fifo_sync_ctrl_if.slave  bus
);
    localparam int SIZE_ADDR = $clog2(SIZE_DEPTH);
    localparam logic [SIZE_ADDR:0] CNT_ONE    = (SIZE_ADDR+1)'(1);
    localparam logic [SIZE_ADDR:0] CNT_FULL   = (SIZE_ADDR+1)'(SIZE_DEPTH);
    localparam logic [SIZE_ADDR:0] CNT_AFULL  = (SIZE_ADDR+1)'(AFULL_LVL);
    localparam logic [SIZE_ADDR:0] CNT_AEMPTY = (SIZE_ADDR+1)'(AEMPTY_LVL);

    logic [SIZE_DATA-1:0] mem_q [SIZE_DEPTH];
    logic [SIZE_ADDR:0]   wr_ptr_q, wr_ptr_d;
    logic [SIZE_ADDR:0]   rd_ptr_q, rd_ptr_d;
    logic [SIZE_ADDR:0]   count_q, count_d;
    logic                 full, empty, wr_acc, rd_acc;
    logic [SIZE_DATA-1:0] head;

    always_comb begin
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        wr_acc   = bus.i_wr_en & ~full & ~bus.i_flush;
        rd_acc   = bus.i_rd_en & ~empty & ~bus.i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem_q[wr_ptr_q[SIZE_ADDR-1:0]] <= bus.i_data;
    end

    assign head               = mem_q[rd_ptr_q[SIZE_ADDR-1:0]];
    assign bus.o_count        = count_q;
    assign bus.o_fifo_full    = full;
    assign bus.o_fifo_empty   = empty;
    assign bus.o_almost_full  = (count_q >= CNT_AFULL);
    assign bus.o_almost_empty = (count_q <= CNT_AEMPTY);

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.o_data  = head;
            assign bus.o_valid = ~empty;
        end else begin : g_reg
            logic [SIZE_DATA-1:0] data_q, data_d;
            logic                 valid_q, valid_d;

            // A flush blocks rd_acc, so o_data simply holds across it.
            always_comb begin
                data_d  = data_q;
                valid_d = rd_acc;
                if (rd_acc) data_d = head;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign bus.o_data  = data_q;
            assign bus.o_valid = valid_q;
        end
    endgenerate

`ifdef FIFO_ERR_FLAGS_EN
    logic ovr_q, ovr_d, udr_q, udr_d;

    // Set takes precedence over a same-cycle clear.
    always_comb begin
        ovr_d = (bus.i_wr_en & full  & ~bus.i_flush) | (ovr_q & ~bus.i_err_clr);
        udr_d = (bus.i_rd_en & empty & ~bus.i_flush) | (udr_q & ~bus.i_err_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            udr_q <= udr_d;
        end
    end

    assign bus.o_error_overrun  = ovr_q;
    assign bus.o_error_underrun = udr_q;
`else
    assign bus.o_error_overrun  = 1'b0;
    assign bus.o_error_underrun = 1'b0;
`endif
endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
- Parametrised single-clock FIFO; next-generation buffer for the Viterbi decoder datapath (symbol input, traceback output staging).
- Adds occupancy count, programmable almost-full/almost-empty watermarks, synchronous flush, selectable standard or first-word-fall-through (FWFT) read mode, and optional sticky error flags.

Parameters:
- SIZE_DATA, 8, data word width in bits (>=1).
- SIZE_DEPTH, 16, number of entries; power of two, >=2. SIZE_ADDR = $clog2(SIZE_DEPTH).
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented without a read.
- AFULL_LVL, SIZE_DEPTH-2, o_almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2, o_almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush, highest priority.
- i_wr_en  in  1  write request.
- i_data  in  SIZE_DATA  write data.
- i_rd_en  in  1  read request (pop in FWFT mode).
- i_err_clr  in  1  clears sticky error flags.
- o_data  out  SIZE_DATA  read data.
- o_valid  out  1  o_data holds a valid word (see Behaviour).
- o_count  out  SIZE_ADDR+1  current occupancy, 0..SIZE_DEPTH.
- o_fifo_full  out  1  count == SIZE_DEPTH.
- o_fifo_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AFULL_LVL.
- o_almost_empty  out  1  count <= AEMPTY_LVL.
- o_error_overrun  out  1  sticky: write attempted while full.
- o_error_underrun  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (async, any time incl. mid-transfer): pointers 0, count 0, o_data 0, o_valid 0, o_fifo_empty 1, o_fifo_full 0, o_almost_empty 1, o_almost_full 0, both error flags 0. Memory contents not reset.
- Pointers are SIZE_ADDR+1 bits; low SIZE_ADDR bits address memory; MSB is the wrap bit; natural binary wrap-around.
- Write accepted iff i_wr_en & ~o_fifo_full & ~i_flush. Read accepted iff i_rd_en & ~o_fifo_empty & ~i_flush. Flags are computed from registered state; a write while full is dropped even if a read is accepted in the same cycle.
- Count: +1 on write only, -1 on read only, unchanged on both or neither. All flags are derived from count and are valid in the cycle following the edge that changed it.
- FWFT=0: on an accepted read, o_data loads the head word at the next edge and o_valid pulses high for exactly that one cycle. o_data holds its value otherwise.
- FWFT=1: o_valid = ~o_fifo_empty; o_data = memory[rd_ptr], combinational. A word written into an empty FIFO appears on o_data with o_valid=1 one cycle after the write edge. An accepted i_rd_en advances to the next word.
- Flush: pointers and count go to 0 at the edge; o_valid goes to 0; o_data is held in FWFT=0. Any write or read requested in the same cycle is dropped. Memory is not cleared.
- Ordering: strict FIFO across any number of wraps.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined: o_error_overrun sets on i_wr_en & o_fifo_full & ~i_flush; o_error_underrun sets on i_rd_en & o_fifo_empty & ~i_flush. Both flags are sticky until i_err_clr. If set and clear occur in the same cycle, set wins. Rejected requests never alter pointers or count.
- Not defined: both error outputs tied 0; i_err_clr ignored; no error registers synthesised.

Test Plan:
- Reset, DEPTH=16, write 0x00..0x0F on consecutive cycles -> o_almost_full=1 when count reaches 14; o_fifo_full=1 and o_count=16 after the 16th edge; a 17th write is dropped.
- FWFT=0, full FIFO, i_rd_en held 16 cycles -> o_data 0x00..0x0F each with a one-cycle o_valid pulse one cycle after the read; o_fifo_empty=1 and o_almost_empty=1 at the end.
- Count=5, simultaneous read and write for 40 cycles with an incrementing pattern -> o_count stays 5, output order matches input exactly across multiple pointer wraps.
- FWFT=1, write 0xA5 into an empty FIFO -> next cycle o_valid=1 and o_data=0xA5 with no rd_en; one-cycle rd_en -> o_valid=0, o_fifo_empty=1.
- Count=9, i_flush asserted together with i_wr_en (0x77) -> o_count=0, o_fifo_empty=1, 0x77 not stored; then write 0x3C -> reads back 0x3C.
- With FIFO_ERR_FLAGS_EN: write while full -> o_error_overrun=1 and stays high, count stays 16, until i_err_clr; read while empty -> o_error_underrun=1. Assert async reset mid-stream -> all outputs return to reset values immediately. Without the macro, both error flags stay 0 throughout.
